// File: rtl/countdown_ctrl_if.sv
// Control and display bus between the button/tick logic, the countdown controller and the digit scanner.
interface countdown_ctrl_if;
    logic       tick;
    logic       start_pause;
    logic       load;
    logic [3:0] preset_0;
    logic [3:0] preset_1;
    logic [3:0] preset_2;
    logic [3:0] preset_3;
    logic [3:0] num_out_0;
    logic [3:0] num_out_1;
    logic [3:0] num_out_2;
    logic [3:0] num_out_3;
    logic [1:0] state;
    logic       done_pulse;
    logic       blank;

    modport master (
        output tick, start_pause, load, preset_0, preset_1, preset_2, preset_3,
        input  num_out_0, num_out_1, num_out_2, num_out_3, state, done_pulse, blank
    );

    modport slave (
        input  tick, start_pause, load, preset_0, preset_1, preset_2, preset_3,
        output num_out_0, num_out_1, num_out_2, num_out_3, state, done_pulse, blank
    );
endinterface

// File: rtl/countdown_ctrl.sv
// MM:SS BCD countdown: preset load, run/pause toggle, 1 Hz decrement with borrow,
// alarm pulse at 00:00 and blink/blank request while done. All outputs registered.
module countdown_ctrl #(
    parameter int unsigned BLINK_HALF = 2
) (
    input  logic            sys_clk,
    input  logic            rst,
    countdown_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [7:0] BLINK_LAST = 8'(BLINK_HALF - 1);

    state_t          state_q, state_d;
    logic [3:0][3:0] dig_q, dig_d;
    logic            done_pulse_q, done_pulse_d;
    logic            blank_q, blank_d;
    logic [7:0]      blink_cnt_q, blink_cnt_d;

    logic [3:0][3:0] preset_sat;
    logic [3:0][3:0] dec_val;
    logic            dec_zero;
    logic            dig_nonzero;

    function automatic logic [3:0] sat_digit(input logic [3:0] v, input logic [3:0] max);
        return (v > max) ? max : v;
    endfunction

    // One-second decrement with BCD borrow; seconds tens wrap to 5, the rest to 9.
    function automatic logic [3:0][3:0] dec_mmss(input logic [3:0][3:0] d);
        logic [3:0][3:0] r;
        r = d;
        if (d[0] != 4'd0) begin
            r[0] = d[0] - 4'd1;
        end else begin
            r[0] = 4'd9;
            if (d[1] != 4'd0) begin
                r[1] = d[1] - 4'd1;
            end else begin
                r[1] = 4'd5;
                if (d[2] != 4'd0) begin
                    r[2] = d[2] - 4'd1;
                end else begin
                    r[2] = 4'd9;
                    r[3] = d[3] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        preset_sat[0] = sat_digit(bus.preset_0, 4'd9);
        preset_sat[1] = sat_digit(bus.preset_1, 4'd5);
        preset_sat[2] = sat_digit(bus.preset_2, 4'd9);
        preset_sat[3] = sat_digit(bus.preset_3, 4'd9);
    end

    assign dec_val     = dec_mmss(dig_q);
    assign dec_zero    = (dec_val == '0);
    assign dig_nonzero = (dig_q != '0);

    always_comb begin
        state_d      = state_q;
        dig_d        = dig_q;
        done_pulse_d = 1'b0;
        blank_d      = 1'b0;
        blink_cnt_d  = blink_cnt_q;

        if (bus.load) begin
            dig_d       = preset_sat;
            state_d     = ST_IDLE;
            blink_cnt_d = 8'd0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start_pause && dig_nonzero) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // A tick that lands on 00:00 takes precedence over a same-cycle pause.
                    if (bus.tick && dig_nonzero) begin
                        dig_d = dec_val;
                        if (dec_zero) begin
                            state_d      = ST_DONE;
                            done_pulse_d = 1'b1;
                            blink_cnt_d  = 8'd0;
                        end else if (bus.start_pause) begin
                            state_d = ST_PAUSE;
                        end
                    end else if (bus.start_pause) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (bus.start_pause) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    blank_d = blank_q;
                    if (bus.tick) begin
                        if (blink_cnt_q >= BLINK_LAST) begin
                            blink_cnt_d = 8'd0;
                            blank_d     = ~blank_q;
                        end else begin
                            blink_cnt_d = blink_cnt_q + 8'd1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            dig_q        <= '0;
            done_pulse_q <= 1'b0;
            blank_q      <= 1'b0;
            blink_cnt_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            dig_q        <= dig_d;
            done_pulse_q <= done_pulse_d;
            blank_q      <= blank_d;
            blink_cnt_q  <= blink_cnt_d;
        end
    end

    assign bus.num_out_0  = dig_q[0];
    assign bus.num_out_1  = dig_q[1];
    assign bus.num_out_2  = dig_q[2];
    assign bus.num_out_3  = dig_q[3];
    assign bus.state      = state_q;
    assign bus.done_pulse = done_pulse_q;
    assign bus.blank      = blank_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl: directed scenarios then random pulses, checked against a
// reference model that keeps the time as a plain count of seconds.
module tb_countdown_ctrl;

    localparam int BLINK_HALF = 2;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;

    countdown_ctrl_if bus ();

    countdown_ctrl #(.BLINK_HALF(BLINK_HALF)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE
    int m_secs;
    int m_state;
    bit m_pulse;
    bit m_blank;
    int m_cnt;

    function automatic logic [15:0] secs_to_bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic int preset_to_secs(input logic [15:0] p);
        int d0, d1, d2, d3;
        d0 = (int'(p[3:0])   > 9) ? 9 : int'(p[3:0]);
        d1 = (int'(p[7:4])   > 5) ? 5 : int'(p[7:4]);
        d2 = (int'(p[11:8])  > 9) ? 9 : int'(p[11:8]);
        d3 = (int'(p[15:12]) > 9) ? 9 : int'(p[15:12]);
        return (d3 * 10 + d2) * 60 + d1 * 10 + d0;
    endfunction

    task automatic model_reset();
        m_secs = 0; m_state = 0; m_pulse = 0; m_blank = 0; m_cnt = 0;
    endtask

    task automatic model_step(input bit t, input bit sp, input bit ld, input logic [15:0] p);
        m_pulse = 0;
        if (ld) begin
            m_secs = preset_to_secs(p); m_state = 0; m_blank = 0; m_cnt = 0;
        end else begin
            case (m_state)
                0: if (sp && m_secs != 0) m_state = 1;
                1: begin
                    if (t) m_secs = m_secs - 1;
                    if (t && m_secs == 0) begin
                        m_state = 3; m_pulse = 1; m_blank = 0; m_cnt = 0;
                    end else if (sp) begin
                        m_state = 2;
                    end
                end
                2: if (sp) m_state = 1;
                default: if (t) begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt == BLINK_HALF) begin
                        m_cnt = 0; m_blank = !m_blank;
                    end
                end
            endcase
        end
    endtask

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] dut_digits();
        return {bus.num_out_3, bus.num_out_2, bus.num_out_1, bus.num_out_0};
    endfunction

    task automatic check_all(input string tag);
        check_eq({tag, ".digits"}, dut_digits(), secs_to_bcd(m_secs));
        check_eq({tag, ".state"},  16'(bus.state), 16'(m_state));
        check_eq({tag, ".pulse"},  16'(bus.done_pulse), 16'(m_pulse));
        check_eq({tag, ".blank"},  16'(bus.blank), 16'(m_blank));
    endtask

    // Called at posedge+1: drive inputs, take one edge, update model, compare.
    task automatic cyc(input string tag, input bit t, input bit sp, input bit ld,
                       input logic [15:0] p = 16'h0);
        bus.tick        = t;
        bus.start_pause = sp;
        bus.load        = ld;
        {bus.preset_3, bus.preset_2, bus.preset_1, bus.preset_0} = p;
        @(posedge sys_clk);
        model_step(t, sp, ld, p);
        #1;
        bus.tick = 1'b0; bus.start_pause = 1'b0; bus.load = 1'b0;
        check_all(tag);
    endtask

    initial begin
        bus.tick = 1'b0; bus.start_pause = 1'b0; bus.load = 1'b0;
        {bus.preset_3, bus.preset_2, bus.preset_1, bus.preset_0} = 16'h0;
        model_reset();
        repeat (2) @(posedge sys_clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // 01:03 -> 00:59 across both borrows
        cyc("t1.load", 0, 0, 1, 16'h0103);
        cyc("t1.start", 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc("t1.tick", 1, 0, 0);
        check_eq("t1.digits_0059", dut_digits(), 16'h0059);
        check_eq("t1.state_run", 16'(bus.state), 16'd1);

        // 00:01 -> DONE, pulse one cycle, blink 0->1->0
        cyc("t2.load", 0, 0, 1, 16'h0001);
        cyc("t2.start", 0, 1, 0);
        cyc("t2.tick", 1, 0, 0);
        check_eq("t2.pulse_hi", 16'(bus.done_pulse), 16'd1);
        check_eq("t2.state_done", 16'(bus.state), 16'd3);
        cyc("t2.after", 0, 0, 0);
        check_eq("t2.pulse_lo", 16'(bus.done_pulse), 16'd0);
        cyc("t2.sp_ignored", 0, 1, 0);
        cyc("t2.b1", 1, 0, 0);
        cyc("t2.gap", 0, 0, 0);
        cyc("t2.b2", 1, 0, 0);
        check_eq("t2.blank_on", 16'(bus.blank), 16'd1);
        cyc("t2.b3", 1, 0, 0);
        cyc("t2.b4", 1, 0, 0);
        check_eq("t2.blank_off", 16'(bus.blank), 16'd0);

        // Pause freezes digits
        cyc("t3.load", 0, 0, 1, 16'h0010);
        cyc("t3.start", 0, 1, 0);
        cyc("t3.pause", 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc("t3.frozen", 1, 0, 0);
        check_eq("t3.digits_0010", dut_digits(), 16'h0010);
        cyc("t3.resume", 0, 1, 0);
        cyc("t3.tick", 1, 0, 0);
        check_eq("t3.digits_0009", dut_digits(), 16'h0009);

        // Saturation and start on zero
        cyc("t4.load_sat", 0, 0, 1, 16'hAC7F);
        check_eq("t4.digits_9959", dut_digits(), 16'h9959);
        cyc("t4.load_zero", 0, 0, 1, 16'h0000);
        cyc("t4.start_zero", 0, 1, 0);
        check_eq("t4.state_idle", 16'(bus.state), 16'd0);

        // DONE beats pause; load beats tick
        cyc("t5.load", 0, 0, 1, 16'h0001);
        cyc("t5.start", 0, 1, 0);
        cyc("t5.tick_sp", 1, 1, 0);
        check_eq("t5.state_done", 16'(bus.state), 16'd3);
        cyc("t5.load2", 0, 0, 1, 16'h0005);
        cyc("t5.start2", 0, 1, 0);
        cyc("t5.tick_load", 1, 0, 1, 16'h0200);
        check_eq("t5.digits_0200", dut_digits(), 16'h0200);

        // Async reset between edges
        cyc("t6.start", 0, 1, 0);
        cyc("t6.tick", 1, 0, 0);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all("t6.async_rst");
        #2 rst = 1'b0;
        @(posedge sys_clk);
        #1;
        check_all("t6.post_rst");

        // Random pulses
        for (int i = 0; i < 800; i++) begin
            bit t, sp, ld;
            logic [15:0] p;
            t  = ($urandom_range(0, 99) < 40);
            sp = ($urandom_range(0, 99) < 8);
            ld = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 1) == 0) p = {12'h000, 4'($urandom_range(0, 15))};
            else                           p = 16'($urandom);
            cyc("rand", t, sp, ld, p);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
